// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - video fetch, CPU request and screen RAM bus bundle for vram_arbiter
interface vram_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              vid_rd;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              cpu_wait;
  logic              vid_miss;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, cpu_rdata, cpu_ack, cpu_wait, vid_miss, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_rd, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, cpu_rdata, cpu_ack, cpu_wait, vid_miss, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - screen RAM arbiter: fixed-priority video reads, CPU req/ack port, run-length guard
module vram_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int MAX_VID_RUN = 4
) (
  input logic           clk_pix,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_VID_RUN + 1);

  typedef enum logic [1:0] {IDLE, RD, ACK} state_t;

  state_t            state;
  logic [CNT_W-1:0]  run_cnt;
  logic [ADDR_W-1:0] last_vid_addr;
  logic              vid_pend;
  logic [7:0]        vid_hold;
  logic [7:0]        cpu_rdata_q;
  logic              vid_miss_q;

  logic cpu_pending;
  logic guard_fire;
  logic vid_grant;
  logic cpu_grant;

  // The slot is exclusive: video wins unless the CPU has waited out the full run.
  always_comb begin
    cpu_pending = bus.cpu_req && (state == IDLE) && !reset;
    guard_fire  = cpu_pending && (run_cnt == CNT_W'(MAX_VID_RUN));
    vid_grant   = bus.vid_rd && !guard_fire;
    cpu_grant   = cpu_pending && !vid_grant;
  end

  assign bus.ram_addr  = vid_grant ? bus.vid_addr : (cpu_grant ? bus.cpu_addr : last_vid_addr);
  assign bus.ram_we    = cpu_grant && bus.cpu_we;
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.vid_data  = vid_pend ? bus.ram_rdata : vid_hold;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = (state == ACK);
  assign bus.cpu_wait  = bus.cpu_req && !bus.cpu_ack && (state != ACK);
  assign bus.vid_miss  = vid_miss_q;

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state         <= IDLE;
      run_cnt       <= '0;
      last_vid_addr <= '0;
      vid_pend      <= 1'b0;
      vid_hold      <= 8'h00;
      cpu_rdata_q   <= 8'h00;
      vid_miss_q    <= 1'b0;
    end else begin
      vid_pend <= vid_grant;
      if (vid_grant) begin
        last_vid_addr <= bus.vid_addr;
      end
      if (vid_pend) begin
        vid_hold <= bus.ram_rdata;
      end
      if (bus.vid_rd && guard_fire) begin
        vid_miss_q <= 1'b1;
      end

      // Saturating count of video wins while the CPU is stuck in IDLE.
      if (cpu_grant || !bus.cpu_req) begin
        run_cnt <= '0;
      end else if (cpu_pending && vid_grant && (run_cnt != CNT_W'(MAX_VID_RUN))) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (cpu_grant) begin
            state <= bus.cpu_we ? ACK : RD;
          end
        end
        RD: begin
          cpu_rdata_q <= bus.ram_rdata;
          state       <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a transaction-level memory model
module tb_vram_arbiter;
  localparam int ADDR_W  = 13;
  localparam int MAX_RUN = 4;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int TXN_LEN = 16;

  logic clk_pix = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .MAX_VID_RUN(MAX_RUN)) dut (
    .clk_pix (clk_pix),
    .reset   (reset),
    .bus     (bus)
  );

  always #20 clk_pix = ~clk_pix;

  logic [7:0]        ram      [DEPTH];
  logic [7:0]        init_val [DEPTH];
  logic [7:0]        shadow   [DEPTH];
  logic              init_go = 1'b0;
  logic              bd_we   = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [7:0]        bd_data = '0;

  // Synchronous screen RAM, read-before-write, one cycle of read latency.
  always @(posedge clk_pix) begin
    if (init_go) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val[i];
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  task automatic next_cycle();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_pix);
  endtask

  task automatic idle_inputs();
    bus.vid_rd    = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic init_mem();
    for (int i = 0; i < DEPTH; i++) begin
      init_val[i] = 8'($urandom);
      shadow[i]   = init_val[i];
    end
    init_go = 1'b1;
    next_cycle();
    init_go = 1'b0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    next_cycle();
    bd_we     = 1'b0;
    shadow[a] = d;
  endtask

  // Holds a request until the ack is seen; reports ack cycle, data and wait behaviour.
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                        output int ack_at, output logic [7:0] rd, output logic wait_ok);
    ack_at  = -1;
    rd      = 8'h00;
    wait_ok = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    for (int c = 0; c < 20 && ack_at < 0; c++) begin
      settle();
      if (bus.cpu_ack === 1'b1) begin
        ack_at = c;
        rd     = bus.cpu_rdata;
        if (bus.cpu_wait !== 1'b0) wait_ok = 1'b0;
      end else if (bus.cpu_wait !== 1'b1) begin
        wait_ok = 1'b0;
      end
      next_cycle();
    end
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    settle();
    checks++; if (bus.vid_data !== 8'h00) begin failures++; $display("FAIL reset_vid_data got=%h exp=00", bus.vid_data); end
    checks++; if (bus.cpu_rdata !== 8'h00) begin failures++; $display("FAIL reset_cpu_rdata got=%h exp=00", bus.cpu_rdata); end
    checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_cpu_ack got=%b exp=0", bus.cpu_ack); end
    checks++; if (bus.vid_miss !== 1'b0) begin failures++; $display("FAIL reset_vid_miss got=%b exp=0", bus.vid_miss); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", bus.ram_we); end
    checks++; if (bus.cpu_wait !== 1'b0) begin failures++; $display("FAIL reset_cpu_wait got=%b exp=0", bus.cpu_wait); end
    next_cycle();
  endtask

  task automatic test_video_only();
    logic [7:0] exp_vd;
    preload(13'h0123, 8'hA5);
    preload(13'h1800, 8'h3C);
    for (int hc = 0; hc < 16; hc++) begin
      bus.vid_rd   = (hc == 10) || (hc == 12);
      bus.vid_addr = (hc == 12) ? 13'h1800 : 13'h0123;
      settle();
      exp_vd = (hc < 11) ? 8'h00 : ((hc < 13) ? 8'hA5 : 8'h3C);
      checks++;
      if (bus.vid_data !== exp_vd) begin
        failures++; $display("FAIL video_only_data hc=%0d got=%h exp=%h", hc, bus.vid_data, exp_vd);
      end
      if (hc >= 10 && hc <= 12) begin
        checks++;
        if (bus.ram_addr !== ((hc == 12) ? 13'h1800 : 13'h0123)) begin
          failures++; $display("FAIL video_only_addr hc=%0d got=%h", hc, bus.ram_addr);
        end
      end
      next_cycle();
    end
    bus.vid_rd = 1'b0;
  endtask

  task automatic test_cpu_write_read();
    int         ack_at;
    logic [7:0] rd;
    logic       wok;
    cpu_op(1'b1, 13'h0456, 8'h5A, ack_at, rd, wok);
    shadow[13'h0456] = 8'h5A;
    checks++; if (ack_at !== 1) begin failures++; $display("FAIL wr_ack_latency got=%0d exp=1", ack_at); end
    checks++; if (wok !== 1'b1) begin failures++; $display("FAIL wr_wait_shape got=%b exp=1", wok); end
    checks++; if (ram[13'h0456] !== 8'h5A) begin failures++; $display("FAIL wr_ram_content got=%h exp=5a", ram[13'h0456]); end
    cpu_op(1'b0, 13'h0456, 8'h00, ack_at, rd, wok);
    checks++; if (ack_at !== 2) begin failures++; $display("FAIL rd_ack_latency got=%0d exp=2", ack_at); end
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL rd_data got=%h exp=5a", rd); end
    checks++; if (wok !== 1'b1) begin failures++; $display("FAIL rd_wait_shape got=%b exp=1", wok); end
    settle();
    checks++; if (bus.cpu_rdata !== 8'h5A) begin failures++; $display("FAIL rd_data_held got=%h exp=5a", bus.cpu_rdata); end
    next_cycle();
  endtask

  task automatic test_contention();
    preload(13'h0200, 8'h11);
    preload(13'h0300, 8'h22);
    bus.vid_rd = 1'b1; bus.vid_addr = 13'h0200;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0300;
    settle();
    checks++; if (bus.ram_addr !== 13'h0200) begin failures++; $display("FAIL cont_video_first got=%h exp=0200", bus.ram_addr); end
    checks++; if (bus.cpu_wait !== 1'b1) begin failures++; $display("FAIL cont_wait got=%b exp=1", bus.cpu_wait); end
    next_cycle();
    bus.vid_rd = 1'b0;
    settle();
    checks++; if (bus.vid_data !== 8'h11) begin failures++; $display("FAIL cont_vid_data got=%h exp=11", bus.vid_data); end
    checks++; if (bus.ram_addr !== 13'h0300) begin failures++; $display("FAIL cont_cpu_grant got=%h exp=0300", bus.ram_addr); end
    next_cycle();
    settle();
    checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL cont_ack_early got=%b exp=0", bus.cpu_ack); end
    next_cycle();
    settle();
    checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL cont_ack got=%b exp=1", bus.cpu_ack); end
    checks++; if (bus.cpu_rdata !== 8'h22) begin failures++; $display("FAIL cont_rdata got=%h exp=22", bus.cpu_rdata); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_guard();
    logic       ack_seen;
    logic [7:0] exp_vd;
    for (int i = 0; i < 8; i++) preload(ADDR_W'(13'h0A00 + i), 8'(8'h80 + i));
    preload(13'h0B00, 8'h5C);
    ack_seen = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0B00;
    for (int c = 0; c < 9; c++) begin
      bus.cpu_req  = !ack_seen;
      bus.vid_rd   = (c < 8);
      bus.vid_addr = ADDR_W'(13'h0A00 + c);
      settle();
      if (c >= 1 && c <= 8) begin
        exp_vd = (c <= 5) ? 8'(8'h80 + ((c - 1 < 3) ? c - 1 : 3)) : 8'(8'h80 + c - 1);
        checks++;
        if (bus.vid_data !== exp_vd) begin failures++; $display("FAIL guard_vid_data c=%0d got=%h exp=%h", c, bus.vid_data, exp_vd); end
      end
      if (c == 4) begin
        checks++; if (bus.ram_addr !== 13'h0B00) begin failures++; $display("FAIL guard_force got=%h exp=0b00", bus.ram_addr); end
      end
      checks++;
      if (bus.vid_miss !== (c >= 5)) begin failures++; $display("FAIL guard_miss c=%0d got=%b exp=%b", c, bus.vid_miss, c >= 5); end
      checks++;
      if (bus.cpu_ack !== (c == 6)) begin failures++; $display("FAIL guard_ack c=%0d got=%b exp=%b", c, bus.cpu_ack, c == 6); end
      if (c == 6) begin
        checks++; if (bus.cpu_rdata !== 8'h5C) begin failures++; $display("FAIL guard_rdata got=%h exp=5c", bus.cpu_rdata); end
      end
      if (bus.cpu_ack === 1'b1) ack_seen = 1'b1;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_write_visibility();
    preload(13'h1AE0, 8'h00);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1AE0; bus.cpu_wdata = 8'hFF;
    settle();
    checks++; if (bus.ram_we !== 1'b1) begin failures++; $display("FAIL vis_ram_we got=%b exp=1", bus.ram_we); end
    next_cycle();
    bus.vid_rd = 1'b1; bus.vid_addr = 13'h1AE0;
    settle();
    checks++; if (bus.cpu_ack !== 1'b1) begin failures++; $display("FAIL vis_ack got=%b exp=1", bus.cpu_ack); end
    next_cycle();
    idle_inputs();
    shadow[13'h1AE0] = 8'hFF;
    settle();
    checks++; if (bus.vid_data !== 8'hFF) begin failures++; $display("FAIL vis_vid_data got=%h exp=ff", bus.vid_data); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    int         ack_at;
    logic [7:0] rd;
    logic       wok;
    preload(13'h0777, 8'h9E);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0777;
    settle();
    next_cycle();
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    settle();
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (bus.cpu_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_ack c=%0d got=%b exp=0", c, bus.cpu_ack); end
      checks++; if (bus.cpu_rdata !== 8'h00) begin failures++; $display("FAIL rst_mid_rdata c=%0d got=%h exp=00", c, bus.cpu_rdata); end
      next_cycle();
    end
    cpu_op(1'b0, 13'h0777, 8'h00, ack_at, rd, wok);
    checks++; if (ack_at !== 2) begin failures++; $display("FAIL rst_after_latency got=%0d exp=2", ack_at); end
    checks++; if (rd !== 8'h9E) begin failures++; $display("FAIL rst_after_rdata got=%h exp=9e", rd); end
  endtask

  // Random video traffic around one CPU access per transaction, checked against a memory-level model.
  task automatic test_random();
    logic              vid   [TXN_LEN];
    logic [ADDR_W-1:0] vaddr [TXN_LEN];
    logic              we, dense, dropped, served, ack_seen, pend_v, miss_m;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d, rd_exp, pend_d, vid_exp;
    int                g, ack_exp;
    init_mem();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    pend_v = 1'b0; pend_d = 8'h00; vid_exp = 8'h00; miss_m = 1'b0; rd_exp = 8'h00;
    for (int t = 0; t < 60; t++) begin
      we    = 1'($urandom_range(0, 1));
      a     = ADDR_W'(13'h0100 + $urandom_range(0, 15));
      d     = 8'($urandom);
      dense = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < TXN_LEN; k++) begin
        vid[k]   = dense ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
        vaddr[k] = ADDR_W'(13'h0100 + $urandom_range(0, 15));
      end
      g = MAX_RUN;
      for (int k = MAX_RUN - 1; k >= 0; k--) if (!vid[k]) g = k;
      dropped  = (g == MAX_RUN) && vid[MAX_RUN];
      ack_exp  = g + (we ? 1 : 2);
      ack_seen = 1'b0;
      bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
      for (int k = 0; k < TXN_LEN; k++) begin
        bus.cpu_req  = !ack_seen;
        bus.vid_rd   = vid[k];
        bus.vid_addr = vaddr[k];
        settle();
        if (pend_v) vid_exp = pend_d;
        checks++;
        if (bus.vid_data !== vid_exp) begin failures++; $display("FAIL rnd_vid_data t=%0d k=%0d got=%h exp=%h", t, k, bus.vid_data, vid_exp); end
        checks++;
        if (bus.cpu_ack !== (k == ack_exp)) begin failures++; $display("FAIL rnd_ack t=%0d k=%0d got=%b exp=%b", t, k, bus.cpu_ack, k == ack_exp); end
        checks++;
        if (bus.cpu_wait !== (k < ack_exp)) begin failures++; $display("FAIL rnd_wait t=%0d k=%0d got=%b exp=%b", t, k, bus.cpu_wait, k < ack_exp); end
        checks++;
        if (bus.vid_miss !== miss_m) begin failures++; $display("FAIL rnd_miss t=%0d k=%0d got=%b exp=%b", t, k, bus.vid_miss, miss_m); end
        if (k == g) begin
          checks++;
          if (bus.ram_addr !== a) begin failures++; $display("FAIL rnd_grant_addr t=%0d got=%h exp=%h", t, bus.ram_addr, a); end
        end
        if (k == ack_exp && !we) begin
          checks++;
          if (bus.cpu_rdata !== rd_exp) begin failures++; $display("FAIL rnd_rdata t=%0d got=%h exp=%h", t, bus.cpu_rdata, rd_exp); end
        end
        if (bus.cpu_ack === 1'b1) ack_seen = 1'b1;
        served = vid[k] && !(dropped && k == g);
        pend_v = served;
        if (served) pend_d = shadow[vaddr[k]];
        if (k == g) begin
          if (dropped) miss_m = 1'b1;
          if (we) shadow[a] = d;
          else    rd_exp = shadow[a];
        end
        next_cycle();
      end
      checks++;
      if (ack_seen !== 1'b1) begin failures++; $display("FAIL rnd_ack_timeout t=%0d got=%b exp=1", t, ack_seen); end
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    init_mem();
    test_reset();
    test_video_only();
    test_cpu_write_read();
    test_contention();
    test_guard();
    test_write_visibility();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
